// File: rtl/serial_sub_16bit_pkg.sv
// serial_sub_16bit_pkg: shared FSM encodings and default width for sequential arithmetic units
package serial_sub_16bit_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/serial_sub_16bit_full_adder_1bit.sv
// full_adder_1bit: single-bit full adder forming the serial datapath
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  // sum and carry of three input bits
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end
endmodule

// File: rtl/serial_sub_16bit.sv
// serial_sub_16bit: bit-serial A-B, one bit per clock LSB first, with borrow/overflow/zero flags
module serial_sub_16bit
  import serial_sub_16bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d, r_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, am_q, am_d, bm_q, bm_d;
  logic             busy_q, busy_d, done_q, done_d, bout_q, bout_d, v_q, v_d, z_q, z_d;
  logic             s, co;
  full_adder_1bit u_fa (
    .a   (a_q[0]),
    .b   (~b_q[0]),
    .cin (c_q),
    .sum (s),
    .cout(co)
  );
  assign r_next = {s, r_q[WIDTH-1:1]};
  // next state: capture on start, shift one bit per RUN cycle, publish flags on the last bit
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    am_d    = am_q;
    bm_d    = bm_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      a_d     = A;
      b_d     = B;
      am_d    = A[WIDTH-1];
      bm_d    = B[WIDTH-1];
      r_d     = '0;
      cnt_d   = '0;
      c_d     = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      r_d   = r_next;
      c_d   = co;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        d_d     = r_next;
        bout_d  = ~co;
        v_d     = (am_q != bm_q) && (r_next[WIDTH-1] != am_q);
        z_d     = (r_next == '0);
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;
  assign Z    = z_q;
endmodule

// File: tb/tb_serial_sub_16bit.sv
// tb_serial_sub_16bit: randomized and directed checks of the serial subtractor against an arithmetic model
module tb_serial_sub_16bit;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, Bout, V, Z;
  logic [W-1:0] D;
  int checks = 0;
  int errors = 0;

  serial_sub_16bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    int sd;
    logic ov;
    d  = a - b;
    sd = int'($signed(a)) - int'($signed(b));
    ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return {d, a < b, ov, d == '0};
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cyc, output int busy_n, output bit overlap, output bit stable);
    logic [W+2:0] prev;
    int n;
    cyc = -1; busy_n = 0; overlap = 0; stable = 1; n = 0;
    while ((busy || done) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    prev = {D, Bout, V, Z};
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_n++;
      if (busy && done) overlap = 1;
      if (done) begin
        cyc = k;
        break;
      end
      if ({D, Bout, V, Z} !== prev) stable = 0;
      if (k == 8) begin A = W'($urandom); B = W'($urandom); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({busy, done, D, Bout, V, Z} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b D=%h Bout=%b V=%b Z=%b, want all 0", busy, done, D, Bout, V, Z);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h0005, 16'h0000, 16'h8000, 16'h1234, 16'h0000, 16'h7FFF};
    logic [W-1:0] tb [6] = '{16'h0003, 16'h0001, 16'h0001, 16'h1234, 16'hFFFF, 16'hFFFF};
    logic [W+2:0] te [6] = '{{16'h0002, 3'b000}, {16'hFFFF, 3'b100}, {16'h7FFF, 3'b010},
                              {16'h0000, 3'b001}, {16'h0001, 3'b100}, {16'h8000, 3'b110}};
    int cyc, bn;
    bit ov, st;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], cyc, bn, ov, st);
      checks++;
      if (cyc !== 17) begin
        errors++;
        $display("FAIL directed_latency %h-%h: done at cycle %0d, want 17", ta[i], tb[i], cyc);
      end
      checks++;
      if ({D, Bout, V, Z} !== te[i]) begin
        errors++;
        $display("FAIL directed_result %h-%h: got D=%h Bout=%b V=%b Z=%b, want D=%h Bout=%b V=%b Z=%b",
                 ta[i], tb[i], D, Bout, V, Z, te[i][W+2:3], te[i][2], te[i][1], te[i][0]);
      end
      checks++;
      if (bn !== W || ov) begin
        errors++;
        $display("FAIL directed_busy %h-%h: busy cycles %0d overlap %b, want %0d and 0", ta[i], tb[i], bn, ov, W);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b one cycle after done, want 0", done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [W+2:0] e;
    int cyc, bn;
    bit ov, st;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = (i % 8 == 0) ? a : W'($urandom);
      e = model(a, b);
      do_op(a, b, cyc, bn, ov, st);
      checks++;
      if (cyc !== 17 || {D, Bout, V, Z} !== e) begin
        errors++;
        $display("FAIL random %h-%h: cycle %0d D=%h Bout=%b V=%b Z=%b, want cycle 17 D=%h Bout=%b V=%b Z=%b",
                 a, b, cyc, D, Bout, V, Z, e[W+2:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] a, b;
    logic [W+2:0] e, got;
    int dones;
    a = W'($urandom); b = W'($urandom);
    e = model(a, b);
    got = '0;
    dones = 0;
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        dones++;
        got = {D, Bout, V, Z};
        start = 1'b0;
      end
      if (start) begin A = W'($urandom); B = W'($urandom); end
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL start_held_dones: got %0d done pulses, want 1", dones);
    end
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL start_held_result %h-%h: got %h, want %h", a, b, got, e);
    end
  endtask

  task automatic test_rst_mid_run();
    int dones, cyc, bn;
    bit ov, st;
    do_op(16'h0009, 16'h0004, cyc, bn, ov, st);
    @(posedge clk); #1;
    A = 16'h4321; B = 16'h0123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, D, Bout, V, Z} !== '0) begin
      errors++;
      $display("FAIL rst_mid_run_outputs: got busy=%b done=%b D=%h Bout=%b V=%b Z=%b, want all 0", busy, done, D, Bout, V, Z);
    end
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (done) dones++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (done) dones++; end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rst_mid_run_done: got %0d done pulses after abort, want 0", dones);
    end
    do_op(16'h0007, 16'h0002, cyc, bn, ov, st);
    checks++;
    if (cyc !== 17 || D !== 16'h0005 || Bout !== 1'b0 || V !== 1'b0 || Z !== 1'b0) begin
      errors++;
      $display("FAIL rst_then_start: cycle %0d D=%h Bout=%b V=%b Z=%b, want cycle 17 D=0005 000", cyc, D, Bout, V, Z);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [W+2:0] e;
    int cyc, bn;
    bit ov, st;
    do_op(16'hABCD, 16'h1111, cyc, bn, ov, st);
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom); b = W'($urandom);
      e = model(a, b);
      do_op(a, b, cyc, bn, ov, st);
      checks++;
      if (cyc !== 17 || {D, Bout, V, Z} !== e) begin
        errors++;
        $display("FAIL back_to_back_result %h-%h: cycle %0d got %h, want cycle 17 %h", a, b, cyc, {D, Bout, V, Z}, e);
      end
      checks++;
      if (st !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_hold: previous result changed before done (stable=%b), want 1", st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_rst_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_sub_16bit.md
SERIAL_SUB_16BIT -- requirements
Module: serial_sub_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH: minuend; captured on an accepted start.
REQ-006 SHALL have port B, input, WIDTH: subtrahend; captured on an accepted start.
REQ-007 SHALL have port busy, output, 1: high while an operation is in progress (RUN state).
REQ-008 SHALL have port done, output, 1: one-cycle pulse when D and the flags are valid.
REQ-009 SHALL have port D, output, WIDTH: difference A-B modulo 2^WIDTH.
REQ-010 SHALL have port Bout, output, 1: borrow, high when unsigned A < unsigned B.
REQ-011 SHALL have port V, output, 1: signed two's-complement overflow of A-B.
REQ-012 SHALL have port Z, output, 1: high when D == 0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, capture A and B into shift registers, set the carry register to 1, clear the bit counter and go to RUN; the start-accept edge is cycle 0.
REQ-015 SHALL compute one bit per RUN cycle LSB-first as A[i] + ~B[i] + carry, shifting the sum bit into the result register from the MSB side and storing carry-out as the next carry.
REQ-016 SHALL stay in RUN for exactly WIDTH cycles, then enter DONE; done SHALL be high for exactly the single DONE cycle (cycle WIDTH+1), after which the FSM returns to IDLE.
REQ-017 SHALL ignore start while in RUN or DONE; a new start is accepted only in IDLE, at the earliest the cycle after done.
REQ-018 SHALL set Bout to the inverse of the final carry-out.
REQ-019 SHALL set V = (A[MSB] != B[MSB]) AND (D[MSB] != A[MSB]), using the captured operands.
REQ-020 SHALL set Z = (D == 0) over all WIDTH bits.
REQ-021 SHALL update D, Bout, V and Z together, coincident with done, and hold them stable until the next accepted start.
REQ-022 SHALL keep busy high in RUN only; busy and done SHALL never be high in the same cycle.
REQ-023 SHALL not let changes on A or B after capture affect the operation in progress.
REQ-024 SHALL handle boundary cases exactly: A == B gives D=0, Z=1, Bout=0; A=0 with B=2^WIDTH-1 gives D=1, Bout=1.

Reset
REQ-025 SHALL, on rst, asynchronously force state IDLE, busy=0, done=0, D=0, Bout=0, V=0, Z=0, and clear the counter, carry and shift registers.
REQ-026 SHALL, when rst is asserted mid-RUN, abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-027 SHALL take its FSM state encodings (2 bits: IDLE, RUN, DONE) and the default WIDTH from the team's shared constants header, so other sequential arithmetic units use the same definitions.
REQ-028 SHALL instantiate exactly one full_adder_1bit as the bit-serial datapath, with inputs A = A shift LSB, B = inverted B shift LSB, Cin = carry register.
REQ-029 SHALL contain FSM, counter, shift registers and flag logic in this module only, with no further sub-modules.

Verification
REQ-030 SHALL check A=0x0005, B=0x0003, start pulse -> done at cycle 17, D=0x0002, Bout=0, V=0, Z=0.
REQ-031 SHALL check A=0x0000, B=0x0001 -> D=0xFFFF, Bout=1, V=0, Z=0.
REQ-032 SHALL check A=0x8000, B=0x0001 -> D=0x7FFF, V=1, Bout=0; and A=0x1234, B=0x1234 -> D=0x0000, Z=1.
REQ-033 SHALL check that start held high during RUN, with A and B changed mid-operation, gives exactly one done and a result from the originally captured operands.
REQ-034 SHALL check rst asserted at RUN cycle 8 -> outputs zero immediately, no done pulse; then a fresh start of 7-2 -> D=0x0005 with done at cycle 17.
REQ-035 SHALL check a back-to-back start in the IDLE cycle following done -> second result correct, with the first result held until the second done.
